ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter_if.sv | 31 +++
 rtl/ram_port_arbiter.sv | 97 +++++++++
 tb/tb_ram_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two RAM requesters, the arbiter and the RAM write/address ports.
// Signal names match the legacy flat port list so existing connections map one-to-one.
interface ram_port_arbiter_if #(
    parameter int unsigned ADDRESS_WIDTH = 13,
    parameter int unsigned DATA_WIDTH    = 64
);
    logic [1:0]                 REQ;
    logic [1:0]                 LOCK;
    logic [1:0]                 GNT;
    logic [2*ADDRESS_WIDTH-1:0] M_ADD_RD1;
    logic [2*ADDRESS_WIDTH-1:0] M_ADD_RD2;
    logic [2*ADDRESS_WIDTH-1:0] M_ADD_WR;
    logic [2*DATA_WIDTH-1:0]    M_DATA_WR;
    logic [1:0]                 M_ENABLE_WR;
    logic [ADDRESS_WIDTH-1:0]   RAM_ADD_RD1;
    logic [ADDRESS_WIDTH-1:0]   RAM_ADD_RD2;
    logic [ADDRESS_WIDTH-1:0]   RAM_ADD_WR;
    logic [DATA_WIDTH-1:0]      RAM_DATA_WR;
    logic                       RAM_ENABLE_WR;
    logic                       BUSY;

    modport master (
        output REQ, LOCK, M_ADD_RD1, M_ADD_RD2, M_ADD_WR, M_DATA_WR, M_ENABLE_WR,
        input  GNT, BUSY, RAM_ADD_RD1, RAM_ADD_RD2, RAM_ADD_WR, RAM_DATA_WR, RAM_ENABLE_WR
    );

    modport slave (
        input  REQ, LOCK, M_ADD_RD1, M_ADD_RD2, M_ADD_WR, M_DATA_WR, M_ENABLE_WR,
        output GNT, BUSY, RAM_ADD_RD1, RAM_ADD_RD2, RAM_ADD_WR, RAM_DATA_WR, RAM_ENABLE_WR
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester RAM port arbiter: tie-break pointer, burst-limited preemption with lock,
// and a zero-latency owner mux onto the RAM address/write ports.
module ram_port_arbiter #(
    parameter int unsigned ADDRESS_WIDTH = 13,
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned MAX_BURST     = 16
) (
    input logic              CLK,
    input logic              RST_N,
    ram_port_arbiter_if.slave bus
);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t          state_q, state_d;
    logic            prio_q, prio_d;
    logic [CW-1:0]   bcnt_q, bcnt_d;
    logic [CW-1:0]   bcnt_inc;
    logic            own, other, enter, enter_to;

    always_comb begin
        own      = (state_q == OWN1);
        other    = ~own;
        // Count includes the current owner cycle, so preemption lands after exactly MAX_BURST cycles.
        bcnt_inc = (bcnt_q == CW'(MAX_BURST)) ? bcnt_q : bcnt_q + CW'(1);
        state_d  = state_q;
        prio_d   = prio_q;
        bcnt_d   = bcnt_q;
        enter    = 1'b0;
        enter_to = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.REQ) begin
                    enter    = 1'b1;
                    enter_to = (bus.REQ == 2'b11) ? prio_q : bus.REQ[1];
                end
            end
            OWN0, OWN1: begin
                bcnt_d = bcnt_inc;
                if (!bus.REQ[own]) begin
                    if (bus.REQ[other]) begin
                        enter    = 1'b1;
                        enter_to = other;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bcnt_inc == CW'(MAX_BURST) && bus.REQ[other] && !bus.LOCK[own]) begin
                    enter    = 1'b1;
                    enter_to = other;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter) begin
            state_d = enter_to ? OWN1 : OWN0;
            prio_d  = ~enter_to;
            bcnt_d  = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Owner slice is picked from registered state only, so the RAM sees it in the first GNT cycle.
    always_comb begin
        bus.GNT           = {state_q == OWN1, state_q == OWN0};
        bus.BUSY          = (state_q == OWN0) || (state_q == OWN1);
        bus.RAM_ADD_RD1   = '0;
        bus.RAM_ADD_RD2   = '0;
        bus.RAM_ADD_WR    = '0;
        bus.RAM_DATA_WR   = '0;
        bus.RAM_ENABLE_WR = 1'b0;
        if (state_q == OWN1) begin
            bus.RAM_ADD_RD1   = bus.M_ADD_RD1[ADDRESS_WIDTH +: ADDRESS_WIDTH];
            bus.RAM_ADD_RD2   = bus.M_ADD_RD2[ADDRESS_WIDTH +: ADDRESS_WIDTH];
            bus.RAM_ADD_WR    = bus.M_ADD_WR[ADDRESS_WIDTH +: ADDRESS_WIDTH];
            bus.RAM_DATA_WR   = bus.M_DATA_WR[DATA_WIDTH +: DATA_WIDTH];
            bus.RAM_ENABLE_WR = bus.M_ENABLE_WR[1];
        end else if (state_q == OWN0) begin
            bus.RAM_ADD_RD1   = bus.M_ADD_RD1[0 +: ADDRESS_WIDTH];
            bus.RAM_ADD_RD2   = bus.M_ADD_RD2[0 +: ADDRESS_WIDTH];
            bus.RAM_ADD_WR    = bus.M_ADD_WR[0 +: ADDRESS_WIDTH];
            bus.RAM_DATA_WR   = bus.M_DATA_WR[0 +: DATA_WIDTH];
            bus.RAM_ENABLE_WR = bus.M_ENABLE_WR[0];
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter (MAX_BURST=4): directed scenarios plus
// randomized traffic checked against an owner/burst-length reference model.
module tb_ram_port_arbiter;
    localparam int unsigned AW = 13;
    localparam int unsigned DW = 64;
    localparam int          MB = 4;

    logic CLK;
    logic RST_N;
    int   checks;
    int   errors;

    // Reference model: current owner (-1 = none), cycles held including the current one, tie pointer.
    int   m_owner;
    int   m_cnt;
    int   m_prio;

    ram_port_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_port_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void m_enter(int x);
        m_owner = x;
        m_prio  = 1 - x;
        m_cnt   = 1;
    endfunction

    function automatic logic [1:0] m_gnt();
        if (m_owner < 0) return 2'b00;
        return (m_owner == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic model_edge();
        logic [1:0] r;
        logic [1:0] l;
        int o;
        r = bus.REQ;
        l = bus.LOCK;
        if (m_owner < 0) begin
            if (r == 2'b01) m_enter(0);
            else if (r == 2'b10) m_enter(1);
            else if (r == 2'b11) m_enter(m_prio);
        end else begin
            o = 1 - m_owner;
            if (!r[m_owner]) begin
                if (r[o]) m_enter(o);
                else m_owner = -1;
            end else if (m_cnt >= MB && r[o] && !l[m_owner]) begin
                m_enter(o);
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        bus.REQ         = 2'b00;
        bus.LOCK        = 2'b00;
        bus.M_ADD_RD1   = '0;
        bus.M_ADD_RD2   = '0;
        bus.M_ADD_WR    = '0;
        bus.M_DATA_WR   = '0;
        bus.M_ENABLE_WR = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        clear_inputs();
        @(negedge CLK);
        @(negedge CLK);
        RST_N   = 1'b1;
        m_owner = -1;
        m_cnt   = 0;
        m_prio  = 0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST_N           = 1'b0;
        bus.REQ         = 2'b11;
        bus.M_ENABLE_WR = 2'b11;
        bus.M_ADD_WR    = {$urandom, $urandom};
        bus.M_ADD_RD1   = {$urandom, $urandom};
        bus.M_DATA_WR   = {$urandom, $urandom, $urandom, $urandom};
        #1;
        checks++;
        if (bus.GNT !== 2'b00 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt got gnt=%b busy=%b exp gnt=00 busy=0", bus.GNT, bus.BUSY);
        end
        checks++;
        if (bus.RAM_ENABLE_WR !== 1'b0 || bus.RAM_ADD_WR !== '0 || bus.RAM_ADD_RD1 !== '0 || bus.RAM_DATA_WR !== '0) begin
            errors++;
            $display("FAIL reset_ram got en=%b wa=%h ra=%h d=%h exp all zero",
                     bus.RAM_ENABLE_WR, bus.RAM_ADD_WR, bus.RAM_ADD_RD1, bus.RAM_DATA_WR);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (bus.GNT !== 2'b00) begin
            errors++;
            $display("FAIL reset_held got gnt=%b exp 00", bus.GNT);
        end
        do_reset();
    endtask

    task automatic test_handover();
        do_reset();
        bus.REQ = 2'b11;
        step();
        checks++;
        if (bus.GNT !== 2'b01 || bus.GNT !== m_gnt()) begin
            errors++;
            $display("FAIL handover_first got %b exp 01", bus.GNT);
        end
        bus.REQ = 2'b10;
        step();
        checks++;
        if (bus.GNT !== 2'b10 || bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL handover_direct got gnt=%b busy=%b exp gnt=10 busy=1", bus.GNT, bus.BUSY);
        end
    endtask

    task automatic test_write_mux();
        do_reset();
        bus.REQ         = 2'b01;
        bus.M_ADD_WR    = {13'd77, 13'd5307};
        bus.M_DATA_WR   = {64'h1234, 64'h2A};
        bus.M_ENABLE_WR = 2'b11;
        step();
        checks++;
        if (bus.GNT !== 2'b01 || bus.RAM_ADD_WR !== 13'd5307 || bus.RAM_DATA_WR !== 64'h2A || bus.RAM_ENABLE_WR !== 1'b1) begin
            errors++;
            $display("FAIL write_mux got gnt=%b wa=%0d d=%h en=%b exp gnt=01 wa=5307 d=2a en=1",
                     bus.GNT, bus.RAM_ADD_WR, bus.RAM_DATA_WR, bus.RAM_ENABLE_WR);
        end
        bus.M_ENABLE_WR = 2'b10;
        #1;
        checks++;
        if (bus.RAM_ENABLE_WR !== 1'b0) begin
            errors++;
            $display("FAIL nonowner_we got en=%b exp 0", bus.RAM_ENABLE_WR);
        end
        bus.M_ENABLE_WR = 2'b11;
        bus.REQ         = 2'b00;
        #1;
        checks++;
        if (bus.RAM_ENABLE_WR !== 1'b1) begin
            errors++;
            $display("FAIL last_cycle_we got en=%b exp 1", bus.RAM_ENABLE_WR);
        end
        step();
        checks++;
        if (bus.GNT !== 2'b00 || bus.RAM_ENABLE_WR !== 1'b0 || bus.RAM_ADD_WR !== '0 || bus.RAM_DATA_WR !== '0) begin
            errors++;
            $display("FAIL idle_zero got gnt=%b en=%b wa=%0d d=%h exp gnt=00 en=0 wa=0 d=0",
                     bus.GNT, bus.RAM_ENABLE_WR, bus.RAM_ADD_WR, bus.RAM_DATA_WR);
        end
    endtask

    task automatic test_burst();
        int n;
        do_reset();
        bus.REQ = 2'b01;
        step();
        bus.REQ = 2'b11;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.GNT == 2'b01) n++;
            else break;
        end
        checks++;
        if (n !== MB || bus.GNT !== 2'b10) begin
            errors++;
            $display("FAIL burst_len got cycles=%0d gnt=%b exp cycles=%0d gnt=10", n, bus.GNT, MB);
        end
        do_reset();
        bus.REQ  = 2'b01;
        bus.LOCK = 2'b01;
        step();
        bus.REQ = 2'b11;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.GNT !== 2'b01) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL lock_hold got %0d non-01 cycles exp 0", n);
        end
        bus.LOCK = 2'b00;
        step();
        checks++;
        if (bus.GNT !== 2'b10) begin
            errors++;
            $display("FAIL lock_release got %b exp 10", bus.GNT);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] exp;
        do_reset();
        bus.REQ = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            step();
            exp = (((k - 1) / MB) % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (bus.GNT !== exp) begin
                errors++;
                $display("FAIL alternate step=%0d got %b exp %b", k, bus.GNT, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.REQ         = 2'b10;
        bus.M_ENABLE_WR = 2'b10;
        step();
        checks++;
        if (bus.GNT !== 2'b10 || bus.RAM_ENABLE_WR !== 1'b1) begin
            errors++;
            $display("FAIL mid_own1 got gnt=%b en=%b exp gnt=10 en=1", bus.GNT, bus.RAM_ENABLE_WR);
        end
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (bus.GNT !== 2'b00 || bus.RAM_ENABLE_WR !== 1'b0 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL mid_async got gnt=%b en=%b busy=%b exp 00/0/0", bus.GNT, bus.RAM_ENABLE_WR, bus.BUSY);
        end
        @(negedge CLK);
        RST_N   = 1'b1;
        m_owner = -1;
        m_cnt   = 0;
        m_prio  = 0;
        bus.REQ = 2'b11;
        step();
        checks++;
        if (bus.GNT !== 2'b01) begin
            errors++;
            $display("FAIL mid_regrant got %b exp 01", bus.GNT);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] ea_rd1, ea_rd2, ea_wr;
        logic [DW-1:0] ed;
        logic          ee;
        logic [2*AW-1:0] t_a;
        logic [2*DW-1:0] t_d;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) bus.REQ[0] = ~bus.REQ[0];
            if ($urandom_range(0, 3) == 0) bus.REQ[1] = ~bus.REQ[1];
            bus.LOCK        = 2'($urandom_range(0, 7) == 0 ? $urandom : 0);
            bus.M_ADD_RD1   = 2*AW'($urandom);
            bus.M_ADD_RD2   = 2*AW'($urandom);
            bus.M_ADD_WR    = 2*AW'($urandom);
            bus.M_DATA_WR   = {$urandom, $urandom, $urandom, $urandom};
            bus.M_ENABLE_WR = 2'($urandom);
            #1;
            ea_rd1 = '0; ea_rd2 = '0; ea_wr = '0; ed = '0; ee = 1'b0;
            if (m_owner >= 0) begin
                t_a = bus.M_ADD_RD1 >> (m_owner * AW); ea_rd1 = t_a[AW-1:0];
                t_a = bus.M_ADD_RD2 >> (m_owner * AW); ea_rd2 = t_a[AW-1:0];
                t_a = bus.M_ADD_WR  >> (m_owner * AW); ea_wr  = t_a[AW-1:0];
                t_d = bus.M_DATA_WR >> (m_owner * DW); ed     = t_d[DW-1:0];
                ee  = bus.M_ENABLE_WR[m_owner];
            end
            checks++;
            if (bus.RAM_ADD_RD1 !== ea_rd1 || bus.RAM_ADD_RD2 !== ea_rd2 || bus.RAM_ADD_WR !== ea_wr ||
                bus.RAM_DATA_WR !== ed || bus.RAM_ENABLE_WR !== ee) begin
                errors++;
                $display("FAIL rand_mux cyc=%0d got r1=%h r2=%h w=%h d=%h en=%b exp r1=%h r2=%h w=%h d=%h en=%b",
                         c, bus.RAM_ADD_RD1, bus.RAM_ADD_RD2, bus.RAM_ADD_WR, bus.RAM_DATA_WR, bus.RAM_ENABLE_WR,
                         ea_rd1, ea_rd2, ea_wr, ed, ee);
            end
            step();
            checks++;
            if (bus.GNT !== m_gnt() || bus.BUSY !== (m_owner >= 0)) begin
                errors++;
                $display("FAIL rand_gnt cyc=%0d got gnt=%b busy=%b exp gnt=%b busy=%b",
                         c, bus.GNT, bus.BUSY, m_gnt(), m_owner >= 0);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_owner = -1;
        m_cnt   = 0;
        m_prio  = 0;
        RST_N   = 1'b1;
        clear_inputs();
        test_reset();
        test_handover();
        test_write_mux();
        test_burst();
        test_alternate();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
